uart_rx_frame_ctrl: RTL and testbench

- Framing controller downstream of the UART byte receiver. It consumes the receiver's one-cycle byte strobes and parses frames of the form SYNC, LEN, LEN payload bytes, CHK.
- Frames are store-and-forward: payload is buffered internally and released on a ready/valid stream only after the checksum passes.
- Reports per-frame errors, and keeps frame and drop counters for the host-side debug registers.

---
 rtl/uart_rx_frame_ctrl_if.sv | 34 +++
 rtl/uart_rx_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frame_ctrl_if
//  Brief    : Byte-in / payload-out bus of the UART frame controller, with
//             the error pulse and the debug counters.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_frame_ctrl_if;
   logic [7:0]  i_data;
   logic        i_valid;
   logic [7:0]  o_data;
   logic        o_valid;
   logic        i_ready;
   logic        o_last;
   logic        o_err;
   logic [1:0]  o_err_code;
   logic [15:0] o_frame_count;
   logic [15:0] o_drop_count;

   // Frame controller side
   modport slave (
      input  i_data, i_valid, i_ready,
      output o_data, o_valid, o_last, o_err, o_err_code,
             o_frame_count, o_drop_count
   );

   // Byte source / payload consumer side
   modport master (
      output i_data, i_valid, i_ready,
      input  o_data, o_valid, o_last, o_err, o_err_code,
             o_frame_count, o_drop_count
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frame_ctrl
//  Brief    : Store-and-forward framing controller behind a UART receiver.
//             Parses SYNC, LEN, payload, CHK; buffers the payload and
//             releases it on a ready/valid stream only after the checksum
//             matches. Reports bad length, bad checksum and inter-byte
//             timeout, and counts delivered frames and dropped bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
   parameter int unsigned MAX_LEN        = 16,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   uart_rx_frame_ctrl_if.slave  bus
);

   // Buffer depth rounded up to a power of two so the index slice covers it
   localparam int unsigned          c_IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned          c_DEPTH    = 1 << c_IDX_W;
   // Timer only has to reach TIMEOUT_CYCLES-1; expiry is detected one step early
   localparam int unsigned          c_TMR_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [c_TMR_W-1:0]   c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]           c_MAX_LEN  = 8'(MAX_LEN);
   localparam logic [15:0]          c_CNT_MAX  = 16'hFFFF;

   localparam logic [2:0] c_ST_IDLE    = 3'd0;
   localparam logic [2:0] c_ST_LEN     = 3'd1;
   localparam logic [2:0] c_ST_PAYLOAD = 3'd2;
   localparam logic [2:0] c_ST_CHK     = 3'd3;
   localparam logic [2:0] c_ST_DRAIN   = 3'd4;

   logic [2:0]         state_q, state_d;
   logic [7:0]         len_q, len_d;
   logic [7:0]         sum_q, sum_d;
   logic [7:0]         wr_idx_q, wr_idx_d;
   logic [7:0]         rd_idx_q, rd_idx_d;
   logic [c_TMR_W-1:0] timer_q, timer_d;
   logic               err_q, err_d;
   logic [1:0]         err_code_q, err_code_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic [15:0]        drop_cnt_q, drop_cnt_d;
   logic [7:0]         mem_q [0:c_DEPTH-1];

   logic               w_valid;
   logic               w_last;
   logic               w_hs;
   logic               w_len_ok;
   logic               w_last_wr;
   logic               w_last_rd;
   logic               w_timed_state;
   logic               w_timeout;
   logic [c_IDX_W-1:0] w_wr_ptr;
   logic [c_IDX_W-1:0] w_rd_ptr;

   assign w_len_ok      = (bus.i_data != 8'd0) && (bus.i_data <= c_MAX_LEN);
   assign w_last_wr     = (wr_idx_q == (len_q - 8'd1));
   assign w_last_rd     = (rd_idx_q == (len_q - 8'd1));
   assign w_hs          = w_valid && bus.i_ready;
   assign w_wr_ptr      = wr_idx_q[c_IDX_W-1:0];
   assign w_rd_ptr      = rd_idx_q[c_IDX_W-1:0];
   assign w_timed_state = (state_q == c_ST_LEN) || (state_q == c_ST_PAYLOAD) ||
                          (state_q == c_ST_CHK);
   // A byte on the expiry cycle wins, so expiry requires a quiet input
   assign w_timeout     = w_timed_state && !bus.i_valid && (timer_q == c_TMR_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= c_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode from the incoming byte strobe and the drain handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_IDLE: begin
            if (bus.i_valid && (bus.i_data == SYNC_BYTE)) begin
               state_d = c_ST_LEN;
            end
         end
         c_ST_LEN: begin
            if (bus.i_valid) begin
               state_d = w_len_ok ? c_ST_PAYLOAD : c_ST_IDLE;
            end else if (w_timeout) begin
               state_d = c_ST_IDLE;
            end
         end
         c_ST_PAYLOAD: begin
            if (bus.i_valid && w_last_wr) begin
               state_d = c_ST_CHK;
            end else if (w_timeout) begin
               state_d = c_ST_IDLE;
            end
         end
         c_ST_CHK: begin
            if (bus.i_valid) begin
               state_d = (bus.i_data == sum_q) ? c_ST_DRAIN : c_ST_IDLE;
            end else if (w_timeout) begin
               state_d = c_ST_IDLE;
            end
         end
         c_ST_DRAIN: begin
            if (w_hs && w_last_rd) begin
               state_d = c_ST_IDLE;
            end
         end
         default: state_d = c_ST_IDLE;
      endcase
   end

   // Stream outputs are a pure function of state; held steady while stalled
   always_comb begin
      w_valid = 1'b0;
      w_last  = 1'b0;
      if (state_q == c_ST_DRAIN) begin
         w_valid = 1'b1;
         w_last  = w_last_rd;
      end
   end

   // Datapath next values: length, checksum, indices, timer, errors, counters
   always_comb begin
      len_d       = len_q;
      sum_d       = sum_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;

      if (!w_timed_state || bus.i_valid || w_timeout) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + 1'b1;
      end

      case (state_q)
         c_ST_IDLE: begin
            if (bus.i_valid && (bus.i_data != SYNC_BYTE) && (drop_cnt_q != c_CNT_MAX)) begin
               drop_cnt_d = drop_cnt_q + 16'd1;
            end
         end
         c_ST_LEN: begin
            if (bus.i_valid) begin
               if (w_len_ok) begin
                  len_d    = bus.i_data;
                  sum_d    = bus.i_data;
                  wr_idx_d = 8'd0;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = 2'd1;
               end
            end
         end
         c_ST_PAYLOAD: begin
            if (bus.i_valid) begin
               sum_d    = sum_q + bus.i_data;
               wr_idx_d = wr_idx_q + 8'd1;
            end
         end
         c_ST_CHK: begin
            if (bus.i_valid) begin
               if (bus.i_data == sum_q) begin
                  rd_idx_d = 8'd0;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = 2'd2;
               end
            end
         end
         c_ST_DRAIN: begin
            // No parse while draining: every arriving byte is lost
            if (bus.i_valid && (drop_cnt_q != c_CNT_MAX)) begin
               drop_cnt_d = drop_cnt_q + 16'd1;
            end
            if (w_hs) begin
               rd_idx_d = rd_idx_q + 8'd1;
               if (w_last_rd && (frame_cnt_q != c_CNT_MAX)) begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end
            end
         end
         default: ;
      endcase

      if (w_timeout) begin
         err_d      = 1'b1;
         err_code_d = 2'd3;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_q       <= 8'd0;
         sum_q       <= 8'd0;
         wr_idx_q    <= 8'd0;
         rd_idx_q    <= 8'd0;
         timer_q     <= '0;
         err_q       <= 1'b0;
         err_code_q  <= 2'd0;
         frame_cnt_q <= 16'd0;
         drop_cnt_q  <= 16'd0;
      end else begin
         len_q       <= len_d;
         sum_q       <= sum_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         timer_q     <= timer_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Payload buffer; contents are don't-care after reset so it is not cleared
   always_ff @(posedge clk) begin
      if ((state_q == c_ST_PAYLOAD) && bus.i_valid) begin
         mem_q[w_wr_ptr] <= bus.i_data;
      end
   end

   assign bus.o_data        = mem_q[w_rd_ptr];
   assign bus.o_valid       = w_valid;
   assign bus.o_last        = w_last;
   assign bus.o_err         = err_q;
   assign bus.o_err_code    = err_code_q;
   assign bus.o_frame_count = frame_cnt_q;
   assign bus.o_drop_count  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_frame_ctrl
//  Brief    : Directed self-checking bench for uart_rx_frame_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_ctrl;

   localparam int c_TMO = 40;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   err_cnt = 0;
   int   err_cyc = 0;
   int   strobe_cyc = 0;

   logic [7:0] q_data[$];
   logic       q_last[$];
   int         q_cyc[$];

   uart_rx_frame_ctrl_if bus ();

   uart_rx_frame_ctrl #(
      .MAX_LEN        (16),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (c_TMO)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Cycle index, advanced at every active edge
   always @(posedge clk) cyc <= cyc + 1;

   // Record handshakes and error pulses away from the active edge
   always @(negedge clk) begin
      if (rst_n && bus.o_valid && bus.i_ready) begin
         q_data.push_back(bus.o_data);
         q_last.push_back(bus.o_last);
         q_cyc.push_back(cyc);
      end
      if (bus.o_err) begin
         err_cnt <= err_cnt + 1;
         err_cyc <= cyc;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got %0d cycles expected fewer", cyc);
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.i_data  = b;
      bus.i_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      strobe_cyc  = cyc;
   endtask

   // Check the held output, then drive one cycle of ready/byte
   task automatic bp_step(input logic rdy, input logic v, input logic [7:0] d,
                          input logic [7:0] exp_d, input logic exp_l);
      check_val("bp_valid", {31'd0, bus.o_valid}, 32'd1);
      check_val("bp_data",  {24'd0, bus.o_data}, {24'd0, exp_d});
      check_val("bp_last",  {31'd0, bus.o_last}, {31'd0, exp_l});
      bus.i_ready = rdy;
      bus.i_valid = v;
      bus.i_data  = d;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
   endtask

   task automatic clear_q();
      q_data.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   initial begin
      logic [7:0] exp_a[3];
      logic [7:0] exp_b[4];
      int         s;

      rst_n       = 1'b0;
      bus.i_data  = 8'd0;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(1);

      check_val("rst_valid",  {31'd0, bus.o_valid}, 32'd0);
      check_val("rst_last",   {31'd0, bus.o_last}, 32'd0);
      check_val("rst_err",    {31'd0, bus.o_err}, 32'd0);
      check_val("rst_code",   {30'd0, bus.o_err_code}, 32'd0);
      check_val("rst_frames", {16'd0, bus.o_frame_count}, 32'd0);
      check_val("rst_drops",  {16'd0, bus.o_drop_count}, 32'd0);

      // Good frame with the consumer always ready: 03+11+22+33 = 69
      exp_a = '{8'h11, 8'h22, 8'h33};
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
      s = strobe_cyc;
      tick(6);
      check_val("good_count", q_data.size(), 32'd3);
      if (q_data.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            check_val("good_data", {24'd0, q_data[i]}, {24'd0, exp_a[i]});
            check_val("good_last", {31'd0, q_last[i]}, (i == 2) ? 32'd1 : 32'd0);
            check_val("good_cyc",  q_cyc[i], s + i);
         end
      end
      check_val("good_frames", {16'd0, bus.o_frame_count}, 32'd1);
      check_val("good_errs",   err_cnt, 32'd0);
      clear_q();

      // Backpressure with two 5A bytes arriving mid-drain
      bus.i_ready = 1'b0;
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
      bp_step(1'b0, 1'b1, 8'h5A, 8'h11, 1'b0);
      bp_step(1'b1, 1'b1, 8'h5A, 8'h11, 1'b0);
      bp_step(1'b0, 1'b0, 8'h00, 8'h22, 1'b0);
      bp_step(1'b1, 1'b0, 8'h00, 8'h22, 1'b0);
      bp_step(1'b0, 1'b0, 8'h00, 8'h33, 1'b1);
      bp_step(1'b1, 1'b0, 8'h00, 8'h33, 1'b1);
      check_val("bp_valid_after", {31'd0, bus.o_valid}, 32'd0);
      tick(2);
      check_val("bp_count", q_data.size(), 32'd3);
      if (q_data.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            check_val("bp_order", {24'd0, q_data[i]}, {24'd0, exp_a[i]});
         end
      end
      check_val("bp_drops",  {16'd0, bus.o_drop_count}, 32'd2);
      check_val("bp_frames", {16'd0, bus.o_frame_count}, 32'd2);
      clear_q();

      // Bad checksum: 02+10+20 = 32, 31 sent
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
      send_byte(8'h20); send_byte(8'h31);
      tick(3);
      check_val("badchk_errs", err_cnt, 32'd1);
      check_val("badchk_code", {30'd0, bus.o_err_code}, 32'd2);
      check_val("badchk_out",  q_data.size(), 32'd0);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
      tick(4);
      check_val("recov_count", q_data.size(), 32'd1);
      if (q_data.size() == 1) begin
         check_val("recov_data", {24'd0, q_data[0]}, 32'h7F);
         check_val("recov_last", {31'd0, q_last[0]}, 32'd1);
      end
      check_val("recov_frames", {16'd0, bus.o_frame_count}, 32'd3);
      clear_q();

      // Bad length: zero, then 17 with a 16-byte buffer
      send_byte(8'hA5); send_byte(8'h00);
      tick(2);
      check_val("len0_errs", err_cnt, 32'd2);
      check_val("len0_code", {30'd0, bus.o_err_code}, 32'd1);
      send_byte(8'hA5); send_byte(8'h11);
      tick(2);
      check_val("len17_errs", err_cnt, 32'd3);
      check_val("len17_code", {30'd0, bus.o_err_code}, 32'd1);
      check_val("badlen_out", q_data.size(), 32'd0);

      // Garbage in IDLE, then an abandoned frame
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
      tick(2);
      check_val("garbage_drops", {16'd0, bus.o_drop_count}, 32'd5);
      send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
      s = strobe_cyc;
      tick(c_TMO + 5);
      check_val("tmo_errs",  err_cnt, 32'd4);
      check_val("tmo_code",  {30'd0, bus.o_err_code}, 32'd3);
      check_val("tmo_cycle", err_cyc, s + c_TMO);
      check_val("tmo_drops", {16'd0, bus.o_drop_count}, 32'd5);

      // Same frame, next byte lands exactly on the expiry cycle
      send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
      tick(c_TMO - 1);
      send_byte(8'h02);
      tick(5);
      check_val("expiry_no_err", err_cnt, 32'd4);
      send_byte(8'h03); send_byte(8'h04); send_byte(8'h0E);
      tick(6);
      exp_b = '{8'h01, 8'h02, 8'h03, 8'h04};
      check_val("expiry_count", q_data.size(), 32'd4);
      if (q_data.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check_val("expiry_data", {24'd0, q_data[i]}, {24'd0, exp_b[i]});
            check_val("expiry_last", {31'd0, q_last[i]}, (i == 3) ? 32'd1 : 32'd0);
         end
      end
      check_val("expiry_frames", {16'd0, bus.o_frame_count}, 32'd4);
      check_val("expiry_code",   {30'd0, bus.o_err_code}, 32'd3);
      clear_q();

      // Reset after the first payload handshake: 02+AA+BB = 67 mod 256
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
      send_byte(8'hBB); send_byte(8'h67);
      tick(1);
      rst_n       = 1'b0;
      bus.i_ready = 1'b0;
      tick(1);
      rst_n       = 1'b1;
      bus.i_ready = 1'b1;
      check_val("mrst_valid",  {31'd0, bus.o_valid}, 32'd0);
      check_val("mrst_last",   {31'd0, bus.o_last}, 32'd0);
      check_val("mrst_err",    {31'd0, bus.o_err}, 32'd0);
      check_val("mrst_code",   {30'd0, bus.o_err_code}, 32'd0);
      check_val("mrst_frames", {16'd0, bus.o_frame_count}, 32'd0);
      check_val("mrst_drops",  {16'd0, bus.o_drop_count}, 32'd0);
      tick(2);
      check_val("mrst_errs",  err_cnt, 32'd4);
      check_val("mrst_count", q_data.size(), 32'd1);
      if (q_data.size() == 1) begin
         check_val("mrst_first", {24'd0, q_data[0]}, 32'hAA);
      end
      clear_q();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
      tick(4);
      check_val("post_count", q_data.size(), 32'd1);
      if (q_data.size() == 1) begin
         check_val("post_data", {24'd0, q_data[0]}, 32'h7F);
         check_val("post_last", {31'd0, q_last[0]}, 32'd1);
      end
      check_val("post_frames", {16'd0, bus.o_frame_count}, 32'd1);
      check_val("post_errs",   err_cnt, 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
